controle_caixa_dagua: RTL
=========================

# controle_caixa_dagua

Water-tank controller for the irrigation FSM system. Owns the 3-bit `water_level` that drives the tank LED column decoder. Sequences refill through the inlet valve. Arbitrates tank water between the two irrigation consumers, sprinkler (aspersão) and drip (gotejamento), with round-robin priority.

## Interface

Parameters:
- `FILL_DIV`, 4: clock cycles per +1 level while filling (1..65535).
- `ASP_DIV`, 2: clock cycles per −1 level while sprinkler is granted (1..65535).
- `GOT_DIV`, 3: clock cycles per −1 level while drip is granted (1..65535).
- `LOW_LEVEL`, 2: refill threshold (0..6).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_asp`  in  1  sprinkler requests water; level-sensitive, held while needed.
- `req_got`  in  1  drip requests water; level-sensitive.
- `water_level`  out  3  current tank level, 0 = empty, 7 = full.
- `valve_in`  out  1  inlet valve open; high exactly while state = FILLING.
- `grant_asp`  out  1  sprinkler may draw water.
- `grant_got`  out  1  drip may draw water.
- `state`  out  2  IDLE=00, FILLING=01, IRR_ASP=10, IRR_GOT=11.
- `low_alarm`  out  1  combinational: `water_level <= LOW_LEVEL`.

## Operation

- All outputs are registered except `low_alarm`. `valve_in`, `grant_asp` and `grant_got` are decoded from the state register.
- Reset values:
  - state IDLE
  - `water_level` 0
  - `valve_in`, `grant_asp`, `grant_got` all 0
  - step counter 0
  - `last_grant` = GOT, so the sprinkler wins the first tie.
- IDLE transitions, in priority order:
  - `water_level <= LOW_LEVEL` → FILLING.
  - Only one request high → that consumer's IRR state.
  - Both requests high → the consumer that is not `last_grant`.
  - Otherwise stay in IDLE.
- FILLING:
  - The step counter counts 0..FILL_DIV−1. At FILL_DIV−1 the level is incremented and the counter reloads to 0.
  - The increment that makes the level 7 also moves the state to IDLE on the same edge.
  - Requests are ignored and stay pending.
- IRR_ASP / IRR_GOT:
  - `last_grant` is set to this consumer on entry.
  - The counter counts to ASP_DIV−1 or GOT_DIV−1, then the level is decremented.
  - The decrement that makes the level equal LOW_LEVEL moves the state to FILLING on the same edge, and the grant drops.
- Request deasserted while granted:
  - Next edge → IDLE with no step.
  - This holds even if the counter is at its terminal value on that edge; the drop wins.
- The step counter clears on every state change. Partial steps are discarded.
- Arithmetic:
  - The level saturates at 0..7 and never wraps.
  - The counter is 16 bits.
  - With DIV=1, the level steps every cycle.
- The grant is exclusive: `grant_asp` and `grant_got` are never high together, and neither is high while `valve_in` is high.

## Timing

- A request sampled high in IDLE produces its grant on the following edge (1-cycle latency).
- The first level step comes DIV cycles after state entry. Each later step comes every DIV cycles.
- A full refill from 0 takes 7×FILL_DIV cycles in FILLING, plus 1 cycle IDLE→FILLING.
- A request drop removes the grant 1 cycle later.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
- After reset release: the first edge moves IDLE→FILLING, because level 0 ≤ LOW_LEVEL.

## Configuration

- `MANUAL_FILL_EN` defined:
  - Adds input `fill_req` (1 bit).
  - In IDLE with `fill_req`=1 and `water_level`<7 → FILLING.
  - This has priority over both irrigation requests.
  - FILLING exit rule is unchanged.
- `MANUAL_FILL_EN` undefined:
  - The port is absent.
  - Refill happens only through the LOW_LEVEL rule.

## Test plan

Defaults: FILL_DIV=4, ASP_DIV=2, GOT_DIV=3, LOW_LEVEL=2.

1. Reset then release, no requests:
   - Expected: state=01 after 1 edge, `valve_in`=1, level increments every 4 cycles.
   - After 28 cycles in FILLING: level=7, state=00, `valve_in`=0.
2. Full tank, `req_asp` held:
   - Expected: `grant_asp`=1 next cycle, level 7→6→…→2 at 2-cycle intervals.
   - On reaching 2: `grant_asp`=0, state=01 on the same edge.
3. Full tank, `req_asp`=`req_got`=1 after reset:
   - Expected: sprinkler granted first.
   - Drop `req_asp` → IDLE one cycle, then `grant_got`=1.
4. Level 5, drip granted, `req_got` dropped on the edge where the counter is at 2:
   - Expected: state=00, level stays 5.
5. Async `reset` pulse mid-IRR_GOT at level 4:
   - Expected: level=0, grants and valve 0 before the next clock edge.
6. (`MANUAL_FILL_EN`) Level 5, IDLE, `fill_req`=1 with `req_asp`=1:
   - Expected: state=01, `grant_asp`=0, level=7 after 8 cycles, then sprinkler granted.

Source files
------------

// File: rtl/controle_caixa_dagua.sv
// Water-tank controller: refills through the inlet valve and shares tank water between
// sprinkler and drip consumers with round-robin priority. Optional MANUAL_FILL_EN adds fill_req.
module controle_caixa_dagua #(
    parameter int unsigned FILL_DIV  = 4,
    parameter int unsigned ASP_DIV   = 2,
    parameter int unsigned GOT_DIV   = 3,
    parameter int unsigned LOW_LEVEL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_asp,
    input  logic       req_got,
`ifdef MANUAL_FILL_EN
    input  logic       fill_req,
`endif
    output logic [2:0] water_level,
    output logic       valve_in,
    output logic       grant_asp,
    output logic       grant_got,
    output logic [1:0] state,
    output logic       low_alarm
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FILLING = 2'b01,
        IRR_ASP = 2'b10,
        IRR_GOT = 2'b11
    } state_t;

    localparam logic [15:0] FILL_LAST = 16'(FILL_DIV - 1);
    localparam logic [15:0] ASP_LAST  = 16'(ASP_DIV - 1);
    localparam logic [15:0] GOT_LAST  = 16'(GOT_DIV - 1);
    localparam logic [2:0]  LOW_LVL   = 3'(LOW_LEVEL);
    localparam logic [2:0]  FULL_LVL  = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_got_q, last_got_d;
    logic        drain_req;
    logic [15:0] drain_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            level_q    <= 3'd0;
            cnt_q      <= 16'd0;
            last_got_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            last_got_q <= last_got_d;
        end
    end

    // Both irrigation states drain the tank the same way; only the request and divider differ.
    always_comb begin
        drain_req  = (state_q == IRR_ASP) ? req_asp : req_got;
        drain_last = (state_q == IRR_ASP) ? ASP_LAST : GOT_LAST;
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        last_got_d = last_got_q;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (level_q <= LOW_LVL) begin
                    state_d = FILLING;
`ifdef MANUAL_FILL_EN
                end else if (fill_req && level_q != FULL_LVL) begin
                    state_d = FILLING;
`endif
                end else if (req_asp && !req_got) begin
                    state_d = IRR_ASP;
                end else if (req_got && !req_asp) begin
                    state_d = IRR_GOT;
                end else if (req_asp && req_got) begin
                    state_d = last_got_q ? IRR_ASP : IRR_GOT;
                end
                if (state_d == IRR_ASP) begin
                    last_got_d = 1'b0;
                end else if (state_d == IRR_GOT) begin
                    last_got_d = 1'b1;
                end
            end
            FILLING: begin
                if (cnt_q == FILL_LAST) begin
                    cnt_d = 16'd0;
                    if (level_q != FULL_LVL) begin
                        level_d = level_q + 3'd1;
                    end
                    if (level_d == FULL_LVL) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                // A dropped request wins even over a pending step on the same edge.
                if (!drain_req) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == drain_last) begin
                    cnt_d = 16'd0;
                    if (level_q != 3'd0) begin
                        level_d = level_q - 3'd1;
                    end
                    if (level_d <= LOW_LVL) begin
                        state_d = FILLING;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    assign state       = state_q;
    assign water_level = level_q;
    assign valve_in    = (state_q == FILLING);
    assign grant_asp   = (state_q == IRR_ASP);
    assign grant_got   = (state_q == IRR_GOT);
    assign low_alarm   = (level_q <= LOW_LVL);

endmodule
